// File: rtl/cv32e40p_pkg.sv
// Shared types and constants for the fault-tolerant EX-stage blocks.
// Replica health states and TMR lane geometry.
package cv32e40p_pkg;

    localparam int FT_N_LANES   = 3;
    localparam int FT_SPARE_IDX = 3;

    typedef enum logic [2:0] {
        FTM_NORMAL,
        FTM_SWAP_WAIT,
        FTM_SPARE_USED,
        FTM_DEGRADED,
        FTM_FAILED
    } ft_mgr_state_e;

endpackage

// File: rtl/cv32e40p_ft_leaky_counter.sv
// Saturating leaky-bucket error counter for one multiplier replica.
// Errors add INC up to CNT_MAX, clean samples remove DEC down to zero.
module cv32e40p_ft_leaky_counter #(
    parameter int CNT_MAX = 255,
    parameter int INC     = 1,
    parameter int DEC     = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         en,
    input  logic                         err,
    input  logic                         clr,
    output logic [$clog2(CNT_MAX+1)-1:0] cnt_o
);

    localparam int CW = $clog2(CNT_MAX + 1);

    logic [CW:0]   inc_sum;
    logic [CW-1:0] inc_val;
    logic [CW-1:0] dec_val;

    assign inc_sum = {1'b0, cnt_o} + (CW+1)'(INC);
    assign inc_val = (inc_sum >= (CW+1)'(CNT_MAX)) ? CW'(CNT_MAX)
                                                   : inc_sum[CW-1:0];
    assign dec_val = (cnt_o >= CW'(DEC)) ? cnt_o - CW'(DEC) : '0;

    // Clear wins; otherwise leak or fill on qualified samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_o <= '0;
        end else if (clr) begin
            cnt_o <= '0;
        end else if (en) begin
            cnt_o <= err ? inc_val : dec_val;
        end
    end

endmodule

// File: rtl/cv32e40p_ft_replica_mgr.sv
// Health manager for the TMR multiplier with one cold spare.
// Tracks replica errors, retires faulty replicas and steers voter lanes.
module cv32e40p_ft_replica_mgr
    import cv32e40p_pkg::*;
#(
    parameter int CNT_MAX  = 255,
    parameter int THRESH   = 100,
    parameter int INC      = 1,
    parameter int DEC      = 2,
    parameter bit SPARE_EN = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       valid_i,
    input  logic       busy_i,
    input  logic [2:0] err_lane_i,
    input  logic       clear_i,
    output logic [2:0] sel_mux_o,
    output logic [3:0] clock_en_o,
    output logic [3:0] perm_fault_o,
    output logic       swap_done_o,
    output logic       degraded_o,
    output logic       failed_o
);

    localparam int CW = $clog2(CNT_MAX + 1);

    ft_mgr_state_e state;
    logic [1:0]    swap_lane;
    logic [CW-1:0] cnt [FT_SPARE_IDX+1];
    logic [1:0]    lane_rep [FT_N_LANES];
    logic [3:0]    cnt_en;
    logic [3:0]    cnt_err;
    logic [3:0]    cnt_clr;
    logic          swap_go;
    logic          hit;
    logic [1:0]    hit_lane;
    logic [1:0]    hit_rep;

    for (genvar i = 0; i < FT_N_LANES; i++) begin : g_map
        assign lane_rep[i] = sel_mux_o[i] ? 2'(i) : 2'(FT_SPARE_IDX);
    end

    assign swap_go = (state == FTM_SWAP_WAIT) && !busy_i;
    assign cnt_clr = {4{clear_i}} | {swap_go, 3'b000};

    // Route each lane's error flag to whichever replica currently feeds it.
    always_comb begin
        cnt_en  = '0;
        cnt_err = '0;
        for (int i = 0; i < FT_N_LANES; i++) begin
            if (valid_i && state != FTM_FAILED
                && !perm_fault_o[lane_rep[i]]) begin
                cnt_en[lane_rep[i]]  = 1'b1;
                cnt_err[lane_rep[i]] = err_lane_i[i];
            end
        end
    end

    for (genvar r = 0; r <= FT_SPARE_IDX; r++) begin : g_cnt
        cv32e40p_ft_leaky_counter #(
            .CNT_MAX (CNT_MAX),
            .INC     (INC),
            .DEC     (DEC)
        ) u_cnt (
            .clk   (clk),
            .rst_n (rst_n),
            .en    (cnt_en[r]),
            .err   (cnt_err[r]),
            .clr   (cnt_clr[r]),
            .cnt_o (cnt[r])
        );
    end

    // Threshold hit on an active healthy replica; lowest lane wins.
    always_comb begin
        hit      = 1'b0;
        hit_lane = '0;
        for (int i = FT_N_LANES - 1; i >= 0; i--) begin
            if (cnt[lane_rep[i]] >= CW'(THRESH)
                && !perm_fault_o[lane_rep[i]]) begin
                hit      = 1'b1;
                hit_lane = 2'(i);
            end
        end
    end

    assign hit_rep = lane_rep[hit_lane];

    // Health FSM with registered steering and status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= FTM_NORMAL;
            swap_lane    <= '0;
            sel_mux_o    <= 3'b111;
            clock_en_o   <= 4'b0111;
            perm_fault_o <= '0;
            swap_done_o  <= 1'b0;
            degraded_o   <= 1'b0;
            failed_o     <= 1'b0;
        end else if (clear_i) begin
            state        <= FTM_NORMAL;
            swap_lane    <= '0;
            sel_mux_o    <= 3'b111;
            clock_en_o   <= 4'b0111;
            perm_fault_o <= '0;
            swap_done_o  <= 1'b0;
            degraded_o   <= 1'b0;
            failed_o     <= 1'b0;
        end else begin
            swap_done_o <= 1'b0;
            unique case (state)
                FTM_NORMAL: begin
                    if (hit) begin
                        if (SPARE_EN) begin
                            state                    <= FTM_SWAP_WAIT;
                            swap_lane                <= hit_lane;
                            clock_en_o[FT_SPARE_IDX] <= 1'b1;
                        end else begin
                            state                 <= FTM_DEGRADED;
                            perm_fault_o[hit_rep] <= 1'b1;
                            degraded_o            <= 1'b1;
                        end
                    end
                end
                FTM_SWAP_WAIT: begin
                    if (!busy_i) begin
                        state                   <= FTM_SPARE_USED;
                        sel_mux_o[swap_lane]    <= 1'b0;
                        clock_en_o[swap_lane]   <= 1'b0;
                        perm_fault_o[swap_lane] <= 1'b1;
                        swap_done_o             <= 1'b1;
                    end
                end
                FTM_SPARE_USED: begin
                    if (hit) begin
                        state                 <= FTM_DEGRADED;
                        perm_fault_o[hit_rep] <= 1'b1;
                        degraded_o            <= 1'b1;
                    end
                end
                FTM_DEGRADED: begin
                    if (hit) begin
                        state                 <= FTM_FAILED;
                        perm_fault_o[hit_rep] <= 1'b1;
                        failed_o              <= 1'b1;
                    end
                end
                FTM_FAILED: begin
                end
                default: state <= FTM_FAILED;
            endcase
        end
    end

endmodule
